// File: rtl/rs_disp_ctl_pkg.sv
// rtl/rs_disp_ctl_pkg.sv - shared types and defaults for the reservation-station dispatch controller
package rs_disp_ctl_pkg;

    localparam int NUM_RS       = 4;
    localparam int NUM_RS_ENTS  = 8;
    localparam int FLUSH_CYCLES = 3;

    localparam int RS_ID_W      = $clog2(NUM_RS);
    localparam int RS_CREDIT_W  = $clog2(NUM_RS_ENTS + 1);

    typedef logic [RS_ID_W-1:0]     t_rs_id;
    typedef logic [RS_CREDIT_W-1:0] t_rs_credit;

    typedef enum logic {
        RS_DISP_RUN   = 1'b0,
        RS_DISP_FLUSH = 1'b1
    } t_rs_disp_state;

    // Dispatched uop as seen by the reservation stations
    typedef struct packed {
        logic [7:0] op;
        logic [5:0] dst;
        logic [5:0] src1;
        logic [5:0] src2;
        logic [5:0] imm;
    } t_uinstr_disp;

endpackage

// File: rtl/rs_disp_ctl_credit_ctr.sv
// rtl/rs_disp_ctl_credit_ctr.sv - per-RS free-entry credit counter with saturation and error pulse
module rs_credit_ctr #(
    parameter int NUM_RS_ENTS = 8,
    parameter int CW          = $clog2(NUM_RS_ENTS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc,
    input  logic          ret,
    input  logic          restore,
    input  logic          hold,
    output logic [CW-1:0] cnt,
    output logic          ovf
);

    localparam logic [CW-1:0] FULL = CW'(NUM_RS_ENTS);

    // A return at full or an allocate at empty is a bookkeeping error; both are flagged and absorbed
    always_comb begin
        ovf = 1'b0;
        if (!restore && !hold) begin
            ovf = (ret && !alloc && cnt == FULL) || (alloc && !ret && cnt == '0);
        end
    end

    // Net count update; restore wins, hold freezes the count while the pipe drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= FULL;
        end else if (restore) begin
            cnt <= FULL;
        end else if (!hold) begin
            if (alloc && !ret && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else if (ret && !alloc && cnt != FULL) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rs_disp_ctl.sv
// rtl/rs_disp_ctl.sv - credit-based dispatch steering and flush backpressure for the RS bank
module rs_disp_ctl
    import rs_disp_ctl_pkg::*;
#(
    parameter int NUM_RS       = rs_disp_ctl_pkg::NUM_RS,
    parameter int NUM_RS_ENTS  = rs_disp_ctl_pkg::NUM_RS_ENTS,
    parameter int FLUSH_CYCLES = rs_disp_ctl_pkg::FLUSH_CYCLES,
    parameter int CS           = $clog2(NUM_RS),
    parameter int CW           = $clog2(NUM_RS_ENTS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       disp_valid_rs0,
    input  logic [CS-1:0]              disp_rs_sel_rs0,
    input  t_uinstr_disp               uinstr_rs0,
    output logic                       disp_stall_rs0,
    output logic [NUM_RS-1:0]          rs_disp_valid_rs0,
    output t_uinstr_disp               rs_uinstr_rs0,
    input  logic [NUM_RS-1:0]          rs_iss_rs2,
    input  logic                       flush,
    output logic [NUM_RS-1:0][CW-1:0]  rs_credits,
    output logic                       credit_err
);

    localparam int             FCW        = $clog2(FLUSH_CYCLES);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [CS:0]    NUM_RS_L   = NUM_RS[CS:0];

    t_rs_disp_state      state;
    logic [FCW-1:0]      flush_cnt;
    logic [FCW-1:0]      flush_cnt_dec;
    logic [NUM_RS-1:0]   ovf;
    logic                sel_ok;
    logic                sel_has_credit;
    logic                alloc_ok;
    logic                hold;
    logic                restore;

    assign rs_uinstr_rs0 = uinstr_rs0;

    assign sel_ok        = ({1'b0, disp_rs_sel_rs0} < NUM_RS_L);
    assign hold          = (state == RS_DISP_FLUSH);
    assign flush_cnt_dec = (flush_cnt == '0) ? '0 : flush_cnt - FCW'(1);
    // The drain ends in the cycle whose decrement reaches zero, so the next cycle can dispatch
    assign restore       = hold && !flush && (flush_cnt_dec == '0);

    // Only the registered credit of the selected RS gates allocation; same-cycle returns do not help
    always_comb begin
        sel_has_credit = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (disp_rs_sel_rs0 == CS'(i)) begin
                sel_has_credit = (rs_credits[i] != '0);
            end
        end
        alloc_ok       = disp_valid_rs0 && (state == RS_DISP_RUN) && !flush && sel_ok && sel_has_credit;
        disp_stall_rs0 = disp_valid_rs0 && !alloc_ok;
        for (int i = 0; i < NUM_RS; i++) begin
            rs_disp_valid_rs0[i] = alloc_ok && (disp_rs_sel_rs0 == CS'(i));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RS; g++) begin : g_ctr
            rs_credit_ctr #(
                .NUM_RS_ENTS (NUM_RS_ENTS),
                .CW          (CW)
            ) u_ctr (
                .clk     (clk),
                .reset   (reset),
                .alloc   (rs_disp_valid_rs0[g]),
                .ret     (rs_iss_rs2[g]),
                .restore (restore),
                .hold    (hold),
                .cnt     (rs_credits[g]),
                .ovf     (ovf[g])
            );
        end
    endgenerate

    // Run/flush sequencing; a repeated flush restarts the drain window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RS_DISP_RUN;
            flush_cnt <= '0;
        end else begin
            case (state)
                RS_DISP_RUN: begin
                    if (flush) begin
                        state     <= RS_DISP_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                RS_DISP_FLUSH: begin
                    if (flush) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else begin
                        flush_cnt <= flush_cnt_dec;
                        if (flush_cnt_dec == '0) begin
                            state <= RS_DISP_RUN;
                        end
                    end
                end
                default: begin
                    state     <= RS_DISP_RUN;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

    // Sticky error: any counter fault or a dispatch aimed at a nonexistent RS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_err <= 1'b0;
        end else if ((|ovf) || (disp_valid_rs0 && !sel_ok)) begin
            credit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rs_disp_ctl.sv
// tb/tb_rs_disp_ctl.sv - scoreboard bench for rs_disp_ctl against a cycle-level credit model
module tb_rs_disp_ctl;
    import rs_disp_ctl_pkg::*;

    localparam int NR = 4;
    localparam int NE = 8;
    localparam int FC = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 disp_valid_rs0 = 1'b0;
    logic [1:0]           disp_rs_sel_rs0 = '0;
    t_uinstr_disp         uinstr_rs0 = '0;
    logic                 disp_stall_rs0;
    logic [NR-1:0]        rs_disp_valid_rs0;
    t_uinstr_disp         rs_uinstr_rs0;
    logic [NR-1:0]        rs_iss_rs2 = '0;
    logic                 flush = 1'b0;
    logic [NR-1:0][3:0]   rs_credits;
    logic                 credit_err;

    rs_disp_ctl dut (
        .clk               (clk),
        .reset             (reset),
        .disp_valid_rs0    (disp_valid_rs0),
        .disp_rs_sel_rs0   (disp_rs_sel_rs0),
        .uinstr_rs0        (uinstr_rs0),
        .disp_stall_rs0    (disp_stall_rs0),
        .rs_disp_valid_rs0 (rs_disp_valid_rs0),
        .rs_uinstr_rs0     (rs_uinstr_rs0),
        .rs_iss_rs2        (rs_iss_rs2),
        .flush             (flush),
        .rs_credits        (rs_credits),
        .credit_err        (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [3:0]  vld;
        logic [15:0] cred;
        logic        err;
        logic [31:0] ui;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    int   m_cred[NR];
    int   m_left;
    bit   m_err;
    bit   last_stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_cred[i] = NE;
        m_left     = 0;
        m_err      = 1'b0;
        last_stall = 1'b0;
    endtask

    // Drive one cycle, predict its outputs from the model, then advance the model past the edge
    task automatic cycle(input logic v, input logic [1:0] sel, input logic [3:0] iss,
                         input logic fl, input logic [31:0] ui);
        exp_t e;
        bit   run;
        bit   ok;
        int   c;
        @(posedge clk);
        #1;
        disp_valid_rs0  = v;
        disp_rs_sel_rs0 = sel;
        rs_iss_rs2      = iss;
        flush           = fl;
        uinstr_rs0      = t_uinstr_disp'(ui);
        run = (m_left == 0);
        ok  = v && run && !fl && (m_cred[sel] > 0);
        e.stall = v && !ok;
        e.vld   = ok ? (4'b0001 << sel) : 4'b0000;
        for (int i = 0; i < NR; i++) e.cred[i*4 +: 4] = 4'(m_cred[i]);
        e.err = m_err;
        e.ui  = ui;
        sb.push_back(e);
        last_stall = e.stall;
        if (run) begin
            for (int i = 0; i < NR; i++) begin
                c = m_cred[i] - ((ok && sel == 2'(i)) ? 1 : 0) + (iss[i] ? 1 : 0);
                if (c > NE) begin
                    c     = NE;
                    m_err = 1'b1;
                end
                m_cred[i] = c;
            end
        end
        if (fl) begin
            m_left = FC - 1;
        end else if (!run) begin
            m_left--;
            if (m_left == 0) for (int i = 0; i < NR; i++) m_cred[i] = NE;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 2'd0, 4'b0000, 1'b0, $urandom);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        disp_valid_rs0 = 1'b0;
        rs_iss_rs2     = '0;
        flush          = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every cycle that has a pending expectation is compared on the falling edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("stall",   32'(disp_stall_rs0),    32'(mon_e.stall));
            chk("alloc",   32'(rs_disp_valid_rs0), 32'(mon_e.vld));
            chk("credits", 32'(rs_credits),        32'(mon_e.cred));
            chk("err",     32'(credit_err),        32'(mon_e.err));
            chk("uinstr",  32'(rs_uinstr_rs0),     mon_e.ui);
        end
    end

    logic       rv;
    logic [1:0] rsel;
    logic [31:0] rui;
    logic [3:0] riss;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle();

        // Fill RS1 then one more dispatch that must stall
        repeat (9) cycle(1'b1, 2'd1, 4'b0000, 1'b0, $urandom);
        idle();

        // RS2 down to 3, then alloc and return together
        do_reset();
        repeat (5) cycle(1'b1, 2'd2, 4'b0000, 1'b0, $urandom);
        cycle(1'b1, 2'd2, 4'b0100, 1'b0, $urandom);
        idle();

        // RS0 empty, a same-cycle return does not relieve the stall
        do_reset();
        repeat (8) cycle(1'b1, 2'd0, 4'b0000, 1'b0, $urandom);
        cycle(1'b1, 2'd0, 4'b0001, 1'b0, 32'h1234_5678);
        cycle(1'b1, 2'd0, 4'b0000, 1'b0, 32'h1234_5678);
        idle();

        // Flush with RS3 at 2, dispatcher keeps trying
        do_reset();
        repeat (6) cycle(1'b1, 2'd3, 4'b0000, 1'b0, $urandom);
        cycle(1'b1, 2'd3, 4'b0000, 1'b1, 32'hcafe_0001);
        repeat (3) cycle(1'b1, 2'd3, 4'b0000, 1'b0, 32'hcafe_0001);
        idle();

        // Second flush in the last drain cycle extends the stall
        do_reset();
        repeat (6) cycle(1'b1, 2'd3, 4'b0000, 1'b0, $urandom);
        cycle(1'b1, 2'd3, 4'b0000, 1'b1, 32'hcafe_0002);
        cycle(1'b1, 2'd3, 4'b1111, 1'b0, 32'hcafe_0002);
        cycle(1'b1, 2'd3, 4'b0000, 1'b1, 32'hcafe_0002);
        repeat (3) cycle(1'b1, 2'd3, 4'b0000, 1'b0, 32'hcafe_0002);
        idle();

        // Overflow sets the sticky error
        do_reset();
        cycle(1'b0, 2'd0, 4'b0001, 1'b0, $urandom);
        repeat (3) idle();

        // Async reset mid-flush with error set and credits depleted
        repeat (6) cycle(1'b1, 2'd3, 4'b0000, 1'b0, $urandom);
        cycle(1'b1, 2'd3, 4'b0000, 1'b1, $urandom);
        cycle(1'b1, 2'd3, 4'b0000, 1'b0, $urandom);
        @(negedge clk);
        #2;
        reset           = 1'b1;
        disp_valid_rs0  = 1'b1;
        disp_rs_sel_rs0 = 2'd3;
        rs_iss_rs2      = '0;
        flush           = 1'b0;
        #1;
        chk("areset_credits", 32'(rs_credits),        32'h0000_8888);
        chk("areset_err",     32'(credit_err),        32'd0);
        chk("areset_stall",   32'(disp_stall_rs0),    32'd0);
        chk("areset_alloc",   32'(rs_disp_valid_rs0), 32'h0000_0008);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        disp_valid_rs0 = 1'b0;
        model_reset();

        // Randomized phases, each starting from reset
        for (int p = 0; p < 5; p++) begin
            do_reset();
            for (int k = 0; k < 300; k++) begin
                if (!last_stall) begin
                    rv   = ($urandom_range(0, 3) != 0);
                    rsel = 2'($urandom_range(0, 3));
                    rui  = $urandom;
                end
                for (int b = 0; b < NR; b++) riss[b] = ($urandom_range(0, 2 + p) == 0);
                cycle(rv, rsel, riss, ($urandom_range(0, 39) == 0), rui);
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
